sha256_padder: RTL and testbench

- Byte-stream front end for the SHA-256 datapath.
- Accepts message bytes over a valid/ready handshake and appends standard SHA-256 padding: 0x80, zero fill, 64-bit big-endian bit length.
- Emits 512-bit blocks already packed in the word order the combinational transform consumes on `data_in`.
- Sits directly upstream of the transform; `blk_first`/`blk_last` let the chaining controller load the IV and capture the digest.

---
 rtl/sha256_padder_if.sv | 24 ++
 rtl/sha256_padder.sv | 109 ++++++++++
 tb/tb_sha256_padder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/sha256_padder_if.sv
// Byte-stream input and 512-bit block output of the SHA-256 padder.
// The slave side is the padder; the master side feeds bytes and takes blocks.
interface sha256_padder_if;
  logic [7:0]   in_data;
  logic         in_keep;
  logic         in_last;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;
  logic         blk_valid;
  logic         blk_ready;

  modport slave (
    input  in_data, in_keep, in_last, in_valid, blk_ready,
    output in_ready, blk_data, blk_first, blk_last, blk_valid
  );

  modport master (
    output in_data, in_keep, in_last, in_valid, blk_ready,
    input  in_ready, blk_data, blk_first, blk_last, blk_valid
  );
endinterface

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs bytes into 512-bit blocks, appends 0x80,
// zero fill and the 64-bit big-endian bit length, adding a length-only block when needed.
module sha256_padder (
  input  logic             clk,
  input  logic             rst,
  sha256_padder_if.slave   bus
);
  typedef enum logic [1:0] {FILL, PAD, PAD2, EMIT} state_t;

  state_t        state_q, state_d;
  logic [511:0]  blk_q;
  logic [5:0]    pos_q;
  logic [60:0]   cnt_q;
  logic          first_q;
  logic          last_q;   // block being built/held is the length-carrying one
  logic          pend_q;   // a PAD2 block follows the current EMIT
  logic          full_q;   // the last byte filled the block (r = 64)
  logic [63:0]   len;

  assign len = {cnt_q, 3'b000};

  // Byte k of the block: word k/4, big-endian within the word.
  function automatic logic [8:0] byte_lo(input logic [5:0] k);
    return {k[5:2], 5'd24} - {4'd0, k[1:0], 3'd0};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: if (bus.in_valid) begin
        if (bus.in_last)                        state_d = PAD;
        else if (bus.in_keep && pos_q == 6'd63) state_d = EMIT;
      end
      PAD:  state_d = EMIT;
      PAD2: state_d = EMIT;
      EMIT: if (bus.blk_ready) state_d = pend_q ? PAD2 : FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == FILL) && !rst;
    bus.blk_valid = (state_q == EMIT);
    bus.blk_first = (state_q == EMIT) && first_q;
    bus.blk_last  = (state_q == EMIT) && last_q;
    bus.blk_data  = blk_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_q   <= '0;
      pos_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b1;
      last_q  <= 1'b0;
      pend_q  <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      case (state_q)
        FILL: if (bus.in_valid && bus.in_keep) begin
          blk_q[byte_lo(pos_q) +: 8] <= bus.in_data;
          pos_q <= pos_q + 6'd1;
          cnt_q <= cnt_q + 61'd1;
          if (bus.in_last && pos_q == 6'd63) full_q <= 1'b1;
        end
        PAD: begin
          if (full_q) begin
            pend_q <= 1'b1;
            last_q <= 1'b0;
          end else if (pos_q <= 6'd55) begin
            blk_q[byte_lo(pos_q) +: 8] <= 8'h80;
            blk_q[479:448] <= len[63:32];
            blk_q[511:480] <= len[31:0];
            last_q <= 1'b1;
          end else begin
            blk_q[byte_lo(pos_q) +: 8] <= 8'h80;
            pend_q <= 1'b1;
            last_q <= 1'b0;
          end
        end
        PAD2: begin
          // Buffer is already zero here; only the marker (if deferred) and length go in.
          if (full_q) blk_q[31:24] <= 8'h80;
          blk_q[479:448] <= len[63:32];
          blk_q[511:480] <= len[31:0];
          last_q <= 1'b1;
          pend_q <= 1'b0;
          full_q <= 1'b0;
        end
        EMIT: if (bus.blk_ready) begin
          blk_q   <= '0;
          pos_q   <= '0;
          first_q <= 1'b0;
          if (last_q) begin
            cnt_q   <= '0;
            first_q <= 1'b1;
            last_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_padder.sv
// Scoreboard bench for sha256_padder: directed messages push expected blocks,
// a negedge monitor pops and compares each accepted block and checks hold stability.
module tb_sha256_padder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sha256_padder_if ifc();
  sha256_padder dut (.clk(clk), .rst(rst), .bus(ifc.slave));

  typedef struct {
    logic [511:0] d;
    logic         f;
    logic         l;
  } blk_t;

  blk_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   bp = 1'b0;
  int   hold = 0;
  logic [511:0] snap_d;
  logic snap_f, snap_l;

  task automatic chk(input string n, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic logic [511:0] sparse(input logic [31:0] w0, input logic [31:0] w14,
                                          input logic [31:0] w15);
    logic [511:0] d;
    d = '0;
    d[31:0]    = w0;
    d[479:448] = w14;
    d[511:480] = w15;
    return d;
  endfunction

  task automatic push(input logic [511:0] d, input logic f, input logic l);
    blk_t b;
    b.d = d; b.f = f; b.l = l;
    exp_q.push_back(b);
  endtask

  // Monitor: decides blk_ready for the coming edge and checks what will be taken.
  always @(negedge clk) begin
    if (rst) begin
      hold = 0;
      ifc.blk_ready = 1'b1;
    end else if (ifc.blk_valid) begin
      if (hold > 0) begin
        chk("hold_data", ifc.blk_data, snap_d);
        chk("hold_first", 512'(ifc.blk_first), 512'(snap_f));
        chk("hold_last", 512'(ifc.blk_last), 512'(snap_l));
        chk("hold_in_ready", 512'(ifc.in_ready), 512'(1'b0));
      end else begin
        snap_d = ifc.blk_data; snap_f = ifc.blk_first; snap_l = ifc.blk_last;
      end
      if (bp && hold < 5) begin
        hold++;
        ifc.blk_ready = 1'b0;
      end else begin
        blk_t e;
        hold = 0;
        ifc.blk_ready = 1'b1;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_block: got %h expected none", ifc.blk_data);
        end else begin
          e = exp_q.pop_front();
          chk("blk_data", ifc.blk_data, e.d);
          chk("blk_first", 512'(ifc.blk_first), 512'(e.f));
          chk("blk_last", 512'(ifc.blk_last), 512'(e.l));
        end
      end
    end else begin
      hold = 0;
      ifc.blk_ready = 1'b1;
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] d, input logic keep, input logic last);
    int t = 0;
    ifc.in_data = d; ifc.in_keep = keep; ifc.in_last = last; ifc.in_valid = 1'b1;
    while (!ifc.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ifc.in_ready) begin
      checks++; failures++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    @(negedge clk);
    if (last) ifc.in_valid = 1'b0;
  endtask

  task automatic drain(input string n);
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL %s_drain: got %0d pending expected 0", n, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic send_abc();
    push(sparse(32'h61626380, 32'h0, 32'h18), 1'b1, 1'b1);
    send(8'h61, 1'b1, 1'b0);
    send(8'h62, 1'b1, 1'b0);
    send(8'h63, 1'b1, 1'b1);
  endtask

  initial begin
    logic [511:0] d;
    ifc.in_data = 8'h0; ifc.in_keep = 1'b0; ifc.in_last = 1'b0; ifc.in_valid = 1'b0;
    ifc.blk_ready = 1'b1;
    #1;
    chk("rst_in_ready", 512'(ifc.in_ready), 512'(1'b0));
    chk("rst_blk_valid", 512'(ifc.blk_valid), 512'(1'b0));
    chk("rst_blk_first", 512'(ifc.blk_first), 512'(1'b0));
    chk("rst_blk_last", 512'(ifc.blk_last), 512'(1'b0));
    chk("rst_blk_data", ifc.blk_data, 512'(0));
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", 512'(ifc.in_ready), 512'(1'b1));
    @(negedge clk);

    // "abc", with first/final latency: PAD cycle then blk_valid.
    send_abc();
    chk("abc_pad_cycle_valid", 512'(ifc.blk_valid), 512'(1'b0));
    @(negedge clk);
    chk("abc_emit_valid", 512'(ifc.blk_valid), 512'(1'b1));
    drain("abc");

    // Empty message.
    push(sparse(32'h80000000, 32'h0, 32'h0), 1'b1, 1'b1);
    send(8'h00, 1'b0, 1'b1);
    drain("empty");

    // 56 zero bytes: marker at byte 56, length in extra block.
    push(sparse(32'h0, 32'h80000000, 32'h0), 1'b1, 1'b0);
    push(sparse(32'h0, 32'h0, 32'h1C0), 1'b0, 1'b1);
    for (int i = 0; i < 56; i++) send(8'h00, 1'b1, i == 55);
    drain("z56");

    // 64 0xFF bytes: full block, marker deferred to the extra block.
    push({512{1'b1}}, 1'b1, 1'b0);
    push(sparse(32'h80000000, 32'h0, 32'h200), 1'b0, 1'b1);
    for (int i = 0; i < 64; i++) send(8'hFF, 1'b1, i == 63);
    drain("ff64");

    // 130 bytes (byte k = k) under 5-cycle backpressure on every block.
    bp = 1'b1;
    for (int b = 0; b < 2; b++) begin
      d = '0;
      for (int w = 0; w < 16; w++) begin
        int k;
        k = 64 * b + 4 * w;
        d[32*w +: 32] = {8'(k), 8'(k + 1), 8'(k + 2), 8'(k + 3)};
      end
      push(d, b == 0, 1'b0);
    end
    push(sparse(32'h80818000, 32'h0, 32'h410), 1'b0, 1'b1);
    for (int i = 0; i < 130; i++) send(8'(i), 1'b1, i == 129);
    drain("bp130");
    bp = 1'b0;

    // Reset in the middle of a message, then "abc" must come out clean.
    for (int i = 0; i < 30; i++) send(8'hA5, 1'b1, 1'b0);
    ifc.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_in_ready", 512'(ifc.in_ready), 512'(1'b0));
    chk("midrst_blk_valid", 512'(ifc.blk_valid), 512'(1'b0));
    chk("midrst_blk_data", ifc.blk_data, 512'(0));
    @(negedge clk);
    rst = 1'b0;
    #1 chk("midrst_in_ready_after", 512'(ifc.in_ready), 512'(1'b1));
    @(negedge clk);
    send_abc();
    drain("abc_after_rst");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
